// File: rtl/mem_port_responder_if.sv
// Line-granular memory port between the L2 and its backing memory.
// Latency: none (signal bundle only).
// Backpressure: requester holds valid until the one-cycle response pulse.
interface mem_port_responder_if #(
  parameter int M_WIDTH = 32
);
  logic               mem_req_valid;
  logic [M_WIDTH-1:0] mem_req_addr;
  logic [127:0]       mem_req_store_data;
  logic [3:0]         mem_req_opcode;
  logic               mem_rsp_valid;
  logic [127:0]       mem_rsp_load_data;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_opcode,
    input  mem_rsp_valid, mem_rsp_load_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_opcode,
    output mem_rsp_valid, mem_rsp_load_data
  );
endinterface

// File: rtl/mem_port_responder.sv
// Zero-initialised line store answering one load/store at a time for the L2.
// Latency: response pulse RSP_LATENCY cycles after request capture.
// Backpressure: single outstanding request; valid is only sampled in IDLE.
module mem_port_responder #(
  parameter int         LG_MEM_LINES = 10,
  parameter int         RSP_LATENCY  = 4,
  parameter logic [3:0] OPC_LOAD     = 4'd4,
  parameter logic [3:0] OPC_STORE    = 4'd7,
  parameter int         M_WIDTH      = 32
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_responder_if.slave mem,
  output logic                init_done,
  output logic                busy,
  output logic                bad_req,
  output logic [63:0]         load_count,
  output logic [63:0]         store_count
);
  localparam int         NUM_LINES = 1 << LG_MEM_LINES;
  localparam logic [7:0] LAT_INIT  = 8'(RSP_LATENCY - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                  state;
  logic [LG_MEM_LINES-1:0] sweep_idx;
  logic [7:0]              lat_cnt;
  logic [127:0]            cap_data;
  logic [127:0]            line_store [NUM_LINES];

  logic [LG_MEM_LINES-1:0] req_line;
  logic                    in_range;
  logic                    is_load;
  logic                    is_store;
  logic                    req_ok;
  logic                    capture;
  logic [127:0]            capture_val;
  logic                    unused_addr_bits;

  // Offset bits inside a line carry no meaning for line-granular accesses.
  assign unused_addr_bits = ^mem.mem_req_addr[3:0];

  assign req_line    = mem.mem_req_addr[LG_MEM_LINES+3:4];
  assign in_range    = (mem.mem_req_addr[M_WIDTH-1:LG_MEM_LINES+4] == '0);
  assign is_load     = (mem.mem_req_opcode == OPC_LOAD);
  assign is_store    = (mem.mem_req_opcode == OPC_STORE);
  assign req_ok      = in_range && (is_load || is_store);
  assign capture     = (state == ST_IDLE) && mem.mem_req_valid;
  // Stores and rejected requests answer with an all-zero line.
  assign capture_val = (req_ok && is_load) ? line_store[req_line] : '0;

  // Single write port: clearing sweep during INIT, accepted stores afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        line_store[sweep_idx] <= '0;
      end else if (capture && req_ok && is_store) begin
        line_store[req_line] <= mem.mem_req_store_data;
      end
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= ST_INIT;
      sweep_idx             <= '0;
      lat_cnt               <= '0;
      cap_data              <= '0;
      mem.mem_rsp_valid     <= 1'b0;
      mem.mem_rsp_load_data <= '0;
      init_done             <= 1'b0;
      busy                  <= 1'b0;
      bad_req               <= 1'b0;
      load_count            <= '0;
      store_count           <= '0;
    end else begin
      mem.mem_rsp_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          sweep_idx <= sweep_idx + LG_MEM_LINES'(1);
          if (sweep_idx == '1) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (mem.mem_req_valid) begin
            cap_data <= capture_val;
            lat_cnt  <= LAT_INIT;
            busy     <= 1'b1;
            if (!req_ok) begin
              bad_req <= 1'b1;
            end else if (is_load) begin
              load_count <= load_count + 64'd1;
            end else begin
              store_count <= store_count + 64'd1;
            end
            // With unit latency the response register is loaded straight from the read.
            if (RSP_LATENCY == 1) begin
              state                 <= ST_RESP;
              mem.mem_rsp_valid     <= 1'b1;
              mem.mem_rsp_load_data <= capture_val;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (lat_cnt == 8'd1) begin
            state                 <= ST_RESP;
            mem.mem_rsp_valid     <= 1'b1;
            mem.mem_rsp_load_data <= cap_data;
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_responder.sv
// Self-checking bench: one default responder plus latency-1 and latency-7 copies.
// Latency: checks every response arrives exactly RSP_LATENCY cycles after capture.
// Backpressure: requester holds valid until the pulse, then drops it for one cycle.
module tb_mem_port_responder;
  localparam logic [3:0] OPC_LOAD  = 4'd4;
  localparam logic [3:0] OPC_STORE = 4'd7;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_s;

  always #5 clk = ~clk;

  // Per-instance drive and observe arrays: 0 = default, 1 = latency 1, 2 = latency 7.
  logic [2:0]   vld;
  logic [3:0]   opc_v  [3];
  logic [31:0]  addr_v [3];
  logic [127:0] sd_v   [3];
  logic [2:0]   rsp_vld;
  logic [127:0] rsp_d  [3];
  logic [2:0]   init_o;
  logic [2:0]   busy_o;
  logic [2:0]   bad_o;
  logic [63:0]  lc_o   [3];
  logic [63:0]  sc_o   [3];

  mem_port_responder_if #(.M_WIDTH(32)) if0 ();
  mem_port_responder_if #(.M_WIDTH(32)) if1 ();
  mem_port_responder_if #(.M_WIDTH(32)) if2 ();

  assign if0.mem_req_valid      = vld[0];
  assign if0.mem_req_opcode     = opc_v[0];
  assign if0.mem_req_addr       = addr_v[0];
  assign if0.mem_req_store_data = sd_v[0];
  assign rsp_vld[0]             = if0.mem_rsp_valid;
  assign rsp_d[0]               = if0.mem_rsp_load_data;

  assign if1.mem_req_valid      = vld[1];
  assign if1.mem_req_opcode     = opc_v[1];
  assign if1.mem_req_addr       = addr_v[1];
  assign if1.mem_req_store_data = sd_v[1];
  assign rsp_vld[1]             = if1.mem_rsp_valid;
  assign rsp_d[1]               = if1.mem_rsp_load_data;

  assign if2.mem_req_valid      = vld[2];
  assign if2.mem_req_opcode     = opc_v[2];
  assign if2.mem_req_addr       = addr_v[2];
  assign if2.mem_req_store_data = sd_v[2];
  assign rsp_vld[2]             = if2.mem_rsp_valid;
  assign rsp_d[2]               = if2.mem_rsp_load_data;

  mem_port_responder #(.LG_MEM_LINES(10), .RSP_LATENCY(4)) dut0 (
    .clk(clk), .reset(rst_a), .mem(if0.slave),
    .init_done(init_o[0]), .busy(busy_o[0]), .bad_req(bad_o[0]),
    .load_count(lc_o[0]), .store_count(sc_o[0])
  );

  mem_port_responder #(.LG_MEM_LINES(6), .RSP_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst_s), .mem(if1.slave),
    .init_done(init_o[1]), .busy(busy_o[1]), .bad_req(bad_o[1]),
    .load_count(lc_o[1]), .store_count(sc_o[1])
  );

  mem_port_responder #(.LG_MEM_LINES(6), .RSP_LATENCY(7)) dut2 (
    .clk(clk), .reset(rst_s), .mem(if2.slave),
    .init_done(init_o[2]), .busy(busy_o[2]), .bad_req(bad_o[2]),
    .load_count(lc_o[2]), .store_count(sc_o[2])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at the next edge and follow it through its whole latency window.
  // Entered and left #1 after a rising edge, so the request is captured at the next edge.
  task automatic req(input int w, input int lat, input logic [3:0] opc,
                     input logic [31:0] addr, input logic [127:0] wd,
                     input logic [127:0] exp, input string tag);
    vld[w]    = 1'b1;
    opc_v[w]  = opc;
    addr_v[w] = addr;
    sd_v[w]   = wd;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      check({tag, " busy"}, {127'd0, busy_o[w]}, 128'd1);
      check({tag, " rsp_valid"}, {127'd0, rsp_vld[w]}, (k == lat) ? 128'd1 : 128'd0);
    end
    check({tag, " rsp_data"}, rsp_d[w], exp);
    vld[w] = 1'b0;
    @(posedge clk); #1;
    check({tag, " busy_after"}, {127'd0, busy_o[w]}, 128'd0);
    check({tag, " rsp_valid_after"}, {127'd0, rsp_vld[w]}, 128'd0);
    check({tag, " data_hold"}, rsp_d[w], exp);
  endtask

  // Random store/load mix against a plain line array kept by the bench.
  task automatic sweep(input int w, input int lat);
    logic [127:0] model [64];
    int           n_ld;
    int           n_st;
    for (int i = 0; i < 64; i++) model[i] = '0;
    n_ld = 0;
    n_st = 0;
    for (int i = 0; i < 100; i++) begin
      int           line;
      logic [31:0]  addr;
      logic [127:0] wd;
      line = $urandom_range(0, 63);
      addr = 32'(line * 16 + $urandom_range(0, 15));
      wd   = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        req(w, lat, OPC_STORE, addr, wd, 128'd0, $sformatf("sweep%0d st%0d", lat, i));
        model[line] = wd;
        n_st++;
      end else begin
        req(w, lat, OPC_LOAD, addr, wd, model[line], $sformatf("sweep%0d ld%0d", lat, i));
        n_ld++;
      end
    end
    check($sformatf("sweep%0d load_count", lat), {64'd0, lc_o[w]}, 128'(n_ld));
    check($sformatf("sweep%0d store_count", lat), {64'd0, sc_o[w]}, 128'(n_st));
    check($sformatf("sweep%0d bad_req", lat), {127'd0, bad_o[w]}, 128'd0);
  endtask

  localparam logic [127:0] LINE_A = 128'hDEADBEEF_00000000_CAFEF00D_12345678;

  initial begin
    logic early;
    vld   = '0;
    rst_a = 1'b1;
    rst_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opc_v[i]  = OPC_LOAD;
      addr_v[i] = '0;
      sd_v[i]   = '0;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst rsp_valid", {127'd0, rsp_vld[0]}, 128'd0);
    check("rst rsp_data", rsp_d[0], 128'd0);
    check("rst busy", {127'd0, busy_o[0]}, 128'd0);
    check("rst init_done", {127'd0, init_o[0]}, 128'd0);
    check("rst bad_req", {127'd0, bad_o[0]}, 128'd0);
    check("rst load_count", {64'd0, lc_o[0]}, 128'd0);
    check("rst store_count", {64'd0, sc_o[0]}, 128'd0);

    // init_done rises exactly 1024 cycles after reset deassert; nothing else moves.
    rst_a = 1'b0;
    rst_s = 1'b0;
    early = 1'b0;
    for (int k = 1; k <= 1024; k++) begin
      @(posedge clk); #1;
      early = early | rsp_vld[0] | busy_o[0] | bad_o[0];
      if (k == 1023) check("init_done at 1023", {127'd0, init_o[0]}, 128'd0);
    end
    check("init_done at 1024", {127'd0, init_o[0]}, 128'd1);
    check("quiet during init", {127'd0, early}, 128'd0);
    check("idle load_count", {64'd0, lc_o[0]}, 128'd0);
    check("idle store_count", {64'd0, sc_o[0]}, 128'd0);

    // Line round trip, offset bits ignored.
    req(0, 4, OPC_STORE, 32'h120, LINE_A, 128'd0, "store 0x120");
    req(0, 4, OPC_LOAD, 32'h12F, 128'd0, LINE_A, "load 0x12F");
    check("rt store_count", {64'd0, sc_o[0]}, 128'd1);
    check("rt load_count", {64'd0, lc_o[0]}, 128'd1);

    // Last line reads back zero after the clearing sweep.
    req(0, 4, OPC_LOAD, 32'h3FF0, 128'd0, 128'd0, "load last line");
    check("last load_count", {64'd0, lc_o[0]}, 128'd2);

    // Error paths.
    req(0, 4, OPC_LOAD, 32'h4000, 128'd0, 128'd0, "load out of range");
    check("oor bad_req", {127'd0, bad_o[0]}, 128'd1);
    check("oor load_count", {64'd0, lc_o[0]}, 128'd2);
    check("oor store_count", {64'd0, sc_o[0]}, 128'd1);
    req(0, 4, 4'd9, 32'h0, LINE_A, 128'd0, "bad opcode");
    check("badopc load_count", {64'd0, lc_o[0]}, 128'd2);
    check("badopc store_count", {64'd0, sc_o[0]}, 128'd1);
    req(0, 4, OPC_LOAD, 32'h120, 128'd0, LINE_A, "load after errors");
    check("sticky bad_req", {127'd0, bad_o[0]}, 128'd1);
    check("post-err load_count", {64'd0, lc_o[0]}, 128'd3);

    // Latency sweep on the latency-1 and latency-7 copies.
    check("lat1 init_done", {127'd0, init_o[1]}, 128'd1);
    check("lat7 init_done", {127'd0, init_o[2]}, 128'd1);
    sweep(1, 1);
    sweep(2, 7);

    // Reset two cycles after a load is captured: no response, everything clears.
    vld[0]    = 1'b1;
    opc_v[0]  = OPC_LOAD;
    addr_v[0] = 32'h120;
    @(posedge clk); #1;
    check("midflight busy", {127'd0, busy_o[0]}, 128'd1);
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    early  = rsp_vld[0];
    check("midrst load_count", {64'd0, lc_o[0]}, 128'd0);
    check("midrst store_count", {64'd0, sc_o[0]}, 128'd0);
    check("midrst init_done", {127'd0, init_o[0]}, 128'd0);
    check("midrst busy", {127'd0, busy_o[0]}, 128'd0);
    check("midrst bad_req", {127'd0, bad_o[0]}, 128'd0);

    // Re-init; a load raised mid-sweep waits for the first IDLE cycle.
    rst_a = 1'b0;
    for (int k = 1; k <= 1024; k++) begin
      @(posedge clk); #1;
      early = early | rsp_vld[0];
      if (k == 500) begin
        vld[0]    = 1'b1;
        opc_v[0]  = OPC_LOAD;
        addr_v[0] = 32'h120;
      end
      if (k == 1023) begin
        check("reinit init_done at 1023", {127'd0, init_o[0]}, 128'd0);
        check("reinit busy at 1023", {127'd0, busy_o[0]}, 128'd0);
      end
    end
    check("reinit init_done at 1024", {127'd0, init_o[0]}, 128'd1);
    check("reinit busy at 1024", {127'd0, busy_o[0]}, 128'd0);
    check("no pulse after reset", {127'd0, early}, 128'd0);
    req(0, 4, OPC_LOAD, 32'h120, 128'd0, 128'd0, "pending load after init");
    check("pending load_count", {64'd0, lc_o[0]}, 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
